reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 75 +++++++
 tb/tb_reg_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register pending-write counters that detect
// read-after-write hazards at decode and retire on writeback.
module reg_scoreboard #(
  parameter int NREGS   = 32,
  parameter int CNTBITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de_valid,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_rs1_used,
  input  logic             de_rs2_used,
  input  logic [4:0]       de_rd,
  input  logic             de_wr_reg,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             stall,
  output logic             stall_raw,
  output logic             stall_full,
  output logic             alloc,
  output logic [NREGS-1:0] busy_vec,
  output logic [6:0]       inflight,
  output logic             err_underflow
);

  logic [CNTBITS-1:0] cnt [NREGS];
  logic [NREGS-1:0]   rel;
  logic [CNTBITS-1:0] eff_rs1, eff_rs2, eff_rd;
  logic               underflow_hit;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    rel      = '0;
    busy_vec = '0;
    for (int r = 1; r < NREGS; r++) begin
      rel[r]      = wb_valid && (wb_rd == 5'(r)) && (cnt[r] != '0);
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // A same-cycle writeback is subtracted before the hazard checks, so the
  // retiring write no longer blocks its reader.
  always_comb begin
    eff_rs1       = cnt[de_rs1] - CNTBITS'(rel[de_rs1]);
    eff_rs2       = cnt[de_rs2] - CNTBITS'(rel[de_rs2]);
    eff_rd        = cnt[de_rd]  - CNTBITS'(rel[de_rd]);
    underflow_hit = wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] == '0);

    stall_raw  = de_valid &&
                 ((de_rs1_used && (de_rs1 != 5'd0) && (eff_rs1 != '0)) ||
                  (de_rs2_used && (de_rs2 != 5'd0) && (eff_rs2 != '0)));
    stall_full = de_valid && de_wr_reg && (de_rd != 5'd0) && (eff_rd == {CNTBITS{1'b1}});
    stall      = stall_raw || stall_full;
    alloc      = de_valid && de_wr_reg && (de_rd != 5'd0) && !stall && !flush;
  end

  // NOTE: state updates use non-blocking assignments; the counter array is
  // reset explicitly because its zero state is architecturally meaningful.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREGS; r++)
        cnt[r] <= cnt[r] + CNTBITS'(alloc && (de_rd == 5'(r))) - CNTBITS'(rel[r]);
      inflight <= inflight + 7'(alloc) - 7'(|rel);
      if (underflow_hit) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic compared against a counting model of pending writes.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_rs1_used, de_rs2_used, de_wr_reg, flush, wb_valid;
  logic [4:0]  de_rs1, de_rs2, de_rd, wb_rd;
  logic        stall, stall_raw, stall_full, alloc, err_underflow;
  logic [31:0] busy_vec;
  logic [6:0]  inflight;

  int total = 0;
  int bad   = 0;

  // Reference model: plain pending-write counts per register.
  int          m_cnt [32];
  bit          m_err;
  bit          e_raw, e_full, e_alloc;
  logic [31:0] e_busy;
  int          e_infl;

  reg_scoreboard dut (
    .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
    .de_wr_reg(de_wr_reg), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .stall_raw(stall_raw), .stall_full(stall_full), .alloc(alloc),
    .busy_vec(busy_vec), .inflight(inflight), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int r);
    if (r == 0) return 0;
    return m_cnt[r] - ((wb_valid && int'(wb_rd) == r && m_cnt[r] > 0) ? 1 : 0);
  endfunction

  task automatic predict();
    e_raw   = de_valid && ((de_rs1_used && eff(int'(de_rs1)) != 0) ||
                           (de_rs2_used && eff(int'(de_rs2)) != 0));
    e_full  = de_valid && de_wr_reg && de_rd != 0 && eff(int'(de_rd)) == 3;
    e_alloc = de_valid && de_wr_reg && de_rd != 0 && !e_raw && !e_full && !flush;
    e_busy  = '0;
    e_infl  = 0;
    for (int r = 1; r < 32; r++) begin
      e_busy[r] = (m_cnt[r] != 0);
      e_infl   += m_cnt[r];
    end
  endtask

  task automatic idle();
    reset = 0; de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0;
    de_rd = 0; de_wr_reg = 0; flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  // Inputs settle, then the caller samples mid-cycle; tick advances one edge.
  task automatic settle();
    #2;
    predict();
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_err = 0;
    end else begin
      if (wb_valid && wb_rd != 0) begin
        if (m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
        else m_err = 1;
      end
      if (e_alloc) m_cnt[de_rd]++;
    end
    #1;
    idle();
    predict();
  endtask

  task automatic write_req(input logic [4:0] rd);
    de_valid = 1; de_wr_reg = 1; de_rd = rd;
  endtask

  task automatic test_reset();
    idle(); reset = 1; tick(); tick();
    settle();
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    total++; if (inflight !== 7'd0) begin bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
  endtask

  task automatic test_raw();
    write_req(5); settle();
    total++; if (alloc !== 1'b1) begin bad++; $display("FAIL raw_alloc_x5: got %b want 1", alloc); end
    tick();
    de_valid = 1; de_rs1 = 5; de_rs1_used = 1; write_req(6); settle();
    total++; if ({stall, stall_raw, alloc} !== 3'b110) begin bad++; $display("FAIL raw_stall: got %b want 110", {stall, stall_raw, alloc}); end
    total++; if (busy_vec[5] !== 1'b1) begin bad++; $display("FAIL raw_busy5: got %b want 1", busy_vec[5]); end
    total++; if (inflight !== 7'd1) begin bad++; $display("FAIL raw_inflight: got %0d want 1", inflight); end
    tick();
  endtask

  task automatic test_wb_bypass();
    de_valid = 1; de_rs1 = 5; de_rs1_used = 1; wb_valid = 1; wb_rd = 5; settle();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL bypass_stall: got %b want 0", stall); end
    tick(); settle();
    total++; if (busy_vec[5] !== 1'b0) begin bad++; $display("FAIL bypass_busy5: got %b want 0", busy_vec[5]); end
    total++; if (inflight !== 7'd0) begin bad++; $display("FAIL bypass_inflight: got %0d want 0", inflight); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 3; i++) begin write_req(7); tick(); end
    write_req(7); settle();
    total++; if ({stall_full, stall, alloc} !== 3'b110) begin bad++; $display("FAIL full_x7: got %b want 110", {stall_full, stall, alloc}); end
    tick(); settle();
    total++; if (inflight !== 7'd3) begin bad++; $display("FAIL full_inflight: got %0d want 3", inflight); end
    // Releasing one slot in the same cycle lets a write through again.
    write_req(7); wb_valid = 1; wb_rd = 7; settle();
    total++; if ({stall_full, alloc} !== 2'b01) begin bad++; $display("FAIL full_relieved: got %b want 01", {stall_full, alloc}); end
    tick();
  endtask

  task automatic test_same_cycle();
    write_req(9); tick();
    write_req(9); wb_valid = 1; wb_rd = 9; settle();
    total++; if (alloc !== 1'b1) begin bad++; $display("FAIL same_alloc: got %b want 1", alloc); end
    tick(); settle();
    total++; if (inflight !== 7'(e_infl) || e_infl != 4) begin bad++; $display("FAIL same_inflight: got %0d want 4", inflight); end
    total++; if (busy_vec[9] !== 1'b1) begin bad++; $display("FAIL same_busy9: got %b want 1", busy_vec[9]); end
    // Drain x9 back to zero: exactly one more release must clear it.
    wb_valid = 1; wb_rd = 9; tick(); settle();
    total++; if (busy_vec[9] !== 1'b0) begin bad++; $display("FAIL same_drain9: got %b want 0", busy_vec[9]); end
  endtask

  task automatic test_flush_x0();
    write_req(4); flush = 1; settle();
    total++; if (alloc !== 1'b0) begin bad++; $display("FAIL flush_alloc: got %b want 0", alloc); end
    tick(); settle();
    total++; if (busy_vec[4] !== 1'b0) begin bad++; $display("FAIL flush_busy4: got %b want 0", busy_vec[4]); end
    write_req(0); settle();
    total++; if (alloc !== 1'b0) begin bad++; $display("FAIL x0_alloc: got %b want 0", alloc); end
    idle(); de_valid = 1; de_rs1_used = 1; de_rs2_used = 1; settle();
    total++; if (stall_raw !== 1'b0) begin bad++; $display("FAIL x0_read: got %b want 0", stall_raw); end
    de_rs2 = 7; flush = 1; settle();
    total++; if (stall_raw !== 1'b1) begin bad++; $display("FAIL flush_not_gating: got %b want 1", stall_raw); end
    idle(); wb_valid = 1; wb_rd = 0; tick(); settle();
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL wb_x0_err: got %b want 0", err_underflow); end
  endtask

  task automatic test_underflow();
    wb_valid = 1; wb_rd = 12; tick(); settle();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_set: got %b want 1", err_underflow); end
    total++; if (inflight !== 7'(e_infl)) begin bad++; $display("FAIL underflow_inflight: got %0d want %0d", inflight, e_infl); end
    tick(); tick(); settle();
    total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_sticky: got %b want 1", err_underflow); end
    reset = 1; write_req(3); wb_valid = 1; wb_rd = 7; tick(); settle();
    total++; if ({err_underflow, busy_vec} !== 33'h0) begin bad++; $display("FAIL underflow_reset: got %h want 0", {err_underflow, busy_vec}); end
    total++; if (inflight !== 7'd0) begin bad++; $display("FAIL underflow_reset_infl: got %0d want 0", inflight); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      de_valid    = $urandom_range(0, 3) != 0;
      de_rs1      = 5'($urandom_range(0, 7));
      de_rs2      = 5'($urandom_range(0, 7));
      de_rs1_used = $urandom_range(0, 1) != 0;
      de_rs2_used = $urandom_range(0, 1) != 0;
      de_rd       = 5'($urandom_range(0, 5));
      de_wr_reg   = $urandom_range(0, 3) != 0;
      flush       = ($urandom_range(0, 9) == 0);
      r           = $urandom_range(0, 7);
      wb_valid    = $urandom_range(0, 2) == 0;
      wb_rd       = (m_cnt[r] > 0) ? 5'(r) : 5'd0;
      settle();
      total++;
      if ({stall_raw, stall_full, stall, alloc} !== {e_raw, e_full, e_raw | e_full, e_alloc}) begin
        bad++;
        $display("FAIL rand_ctrl c=%0d: got %b want %b", c, {stall_raw, stall_full, stall, alloc},
                 {e_raw, e_full, e_raw | e_full, e_alloc});
      end
      total++;
      if (busy_vec !== e_busy || inflight !== 7'(e_infl) || err_underflow !== m_err) begin
        bad++;
        $display("FAIL rand_state c=%0d: got %h/%0d/%b want %h/%0d/%b", c, busy_vec, inflight,
                 err_underflow, e_busy, e_infl, m_err);
      end
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0;
    idle();
    #1;
    test_reset();
    test_raw();
    test_wb_bypass();
    test_full();
    test_same_cycle();
    test_flush_x0();
    test_underflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
